// File: rtl/dmem_responder_pkg.sv
// Shared types and default constants for the data-memory responder.
// Holds the FSM state encoding, the latched operation type and the counter width.
package dmem_responder_pkg;

  localparam int DEFAULT_N       = 64;
  localparam int DEFAULT_DEPTH   = 64;
  localparam int DEFAULT_LATENCY = 2;

  // Wide enough for the largest legal LATENCY-1 (14).
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_t;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } dmem_op_t;

endpackage

// File: rtl/dmem_array.sv
// Word storage for dmem_responder: one synchronous write port and a registered,
// enable-gated read port whose output register is the only resettable state here.
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter  int N     = DEFAULT_N,
  parameter  int DEPTH = DEFAULT_DEPTH,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en_i,
  input  logic             rd_en_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [N-1:0]     wr_data_i,
  output logic [N-1:0]     rd_data_o
);

  logic [N-1:0] mem_q [DEPTH];
  logic [N-1:0] rd_data_q;

  // NOTE: the storage array has no reset branch; its contents must survive a
  // pipeline reset, and leaving it out keeps it mappable to plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[idx_i] <= wr_data_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[idx_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: accepts one load/store from IDLE, waits
// LATENCY cycles, commits to dmem_array, then pulses DM_ready for one cycle.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int N       = DEFAULT_N,
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int LATENCY = DEFAULT_LATENCY
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] DM_addr,
  input  logic [N-1:0] DM_writeData,
  input  logic         DM_writeEnable,
  input  logic         DM_readEnable,
  output logic [N-1:0] DM_readData,
  output logic         DM_ready,
  output logic         DM_busy
);

  localparam int IDX_W = $clog2(DEPTH);

  dmem_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [N-1:0]     wdata_q, wdata_d;
  dmem_op_t         op_q, op_d;
  logic             req;
  logic             commit;
  logic             wr_en;
  logic             rd_en;
  logic             unused_addr_bits;

  assign req = DM_readEnable | DM_writeEnable;

  // Byte offset and bits above the word index are deliberately dropped (wrap).
  assign unused_addr_bits = ^{DM_addr[N-1:IDX_W+3], DM_addr[2:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Access latches only matter once WAIT is entered, so they need no reset.
  always_ff @(posedge clk) begin
    idx_q   <= idx_d;
    wdata_q <= wdata_d;
    op_q    <= op_d;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    wdata_d  = wdata_q;
    op_d     = op_q;
    commit   = 1'b0;
    DM_busy  = 1'b0;
    DM_ready = 1'b0;
    case (state_q)
      IDLE: begin
        DM_busy = req;
        if (req) begin
          idx_d   = DM_addr[IDX_W+2:3];
          wdata_d = DM_writeData;
          op_d    = DM_writeEnable ? OP_WRITE : OP_READ;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        DM_busy = 1'b1;
        if (cnt_q == '0) begin
          commit  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        DM_ready = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A reset landing on the commit edge aborts the access entirely.
  assign wr_en = commit && (op_q == OP_WRITE) && !reset;
  assign rd_en = commit && (op_q == OP_READ) && !reset;

  dmem_array #(
    .N    (N),
    .DEPTH(DEPTH)
  ) u_array (
    .clk      (clk),
    .reset    (reset),
    .wr_en_i  (wr_en),
    .rd_en_i  (rd_en),
    .idx_i    (idx_q),
    .wr_data_i(wdata_q),
    .rd_data_o(DM_readData)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a driver issues accesses and pushes the
// expected responses, a monitor pops and compares on every DM_ready pulse.
module tb_dmem_responder;

  localparam int N     = 64;
  localparam int DEPTH = 64;
  localparam int LAT   = 2;

  typedef struct {
    int          issue;
    logic [63:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  DM_addr, DM_writeData, DM_readData;
  logic          DM_writeEnable, DM_readEnable, DM_ready, DM_busy;

  logic [N-1:0]  l1_addr, l1_wdata, l1_rdata;
  logic          l1_we, l1_re, l1_ready, l1_busy;

  int            cyc = 0;
  int            n_vec = 0;
  int            n_err = 0;
  exp_t          exp_q[$];
  logic [63:0]   ref_mem [DEPTH];
  logic [63:0]   ref_rd;
  bit            prev_ready = 1'b0;
  exp_t          mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder #(.N(N), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk           (clk),
    .reset         (reset),
    .DM_addr       (DM_addr),
    .DM_writeData  (DM_writeData),
    .DM_writeEnable(DM_writeEnable),
    .DM_readEnable (DM_readEnable),
    .DM_readData   (DM_readData),
    .DM_ready      (DM_ready),
    .DM_busy       (DM_busy)
  );

  dmem_responder #(.N(N), .DEPTH(DEPTH), .LATENCY(1)) dut_l1 (
    .clk           (clk),
    .reset         (reset),
    .DM_addr       (l1_addr),
    .DM_writeData  (l1_wdata),
    .DM_writeEnable(l1_we),
    .DM_readEnable (l1_re),
    .DM_readData   (l1_rdata),
    .DM_ready      (l1_ready),
    .DM_busy       (l1_busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int word_of(input logic [63:0] a);
    return int'((a >> 3) % DEPTH);
  endfunction

  // Monitor: every ready pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && DM_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ready", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("rdata", DM_readData, mon_e.data);
        check("ready_latency", 64'(cyc - mon_e.issue), 64'(LAT + 1));
      end
      check("ready_single_cycle", 64'(prev_ready), 64'd0);
    end
    prev_ready = DM_ready;
  end

  // Present one access, update the reference model, then wait for its ready
  // pulse while scrambling the address/data bus during WAIT.
  task automatic access(input bit we, input bit re, input logic [63:0] addr,
                        input logic [63:0] data, input bit hold, output int rdy_cyc);
    exp_t e;
    int   busy_cnt;
    bit   seen;
    @(negedge clk);
    DM_addr        = addr;
    DM_writeData   = data;
    DM_writeEnable = we;
    DM_readEnable  = re;
    if (we) ref_mem[word_of(addr)] = data;
    else    ref_rd = ref_mem[word_of(addr)];
    e.issue = cyc;
    e.data  = ref_rd;
    exp_q.push_back(e);
    #1;
    busy_cnt = DM_busy ? 1 : 0;
    seen     = 1'b0;
    rdy_cyc  = -1;
    for (int n = 0; n < LAT + 10 && !seen; n++) begin
      @(negedge clk);
      if (DM_busy) busy_cnt++;
      if (DM_ready) begin
        seen    = 1'b1;
        rdy_cyc = cyc;
      end else begin
        DM_addr      = {$urandom(), $urandom()};
        DM_writeData = {$urandom(), $urandom()};
      end
    end
    check("ready_seen", 64'(seen), 64'd1);
    check("busy_cycles", 64'(busy_cnt), 64'(LAT + 1));
    if (!hold) begin
      DM_writeEnable = 1'b0;
      DM_readEnable  = 1'b0;
    end
  endtask

  task automatic access_l1(input bit we, input logic [63:0] addr,
                           input logic [63:0] data, input logic [63:0] exp_rd);
    int busy_cnt;
    int issue;
    bit seen;
    @(negedge clk);
    l1_addr  = addr;
    l1_wdata = data;
    l1_we    = we;
    l1_re    = !we;
    issue    = cyc;
    #1;
    busy_cnt = l1_busy ? 1 : 0;
    seen     = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (l1_busy) busy_cnt++;
      if (l1_ready) begin
        seen = 1'b1;
        check("l1_latency", 64'(cyc - issue), 64'd2);
        check("l1_rdata", l1_rdata, exp_rd);
      end
    end
    check("l1_ready_seen", 64'(seen), 64'd1);
    check("l1_busy_cycles", 64'(busy_cnt), 64'd2);
    l1_we = 1'b0;
    l1_re = 1'b0;
  endtask

  initial begin
    int r1, r2, dummy, gap;
    bit hold;
    int op;

    reset = 1'b1;
    DM_addr = '0; DM_writeData = '0; DM_writeEnable = 1'b0; DM_readEnable = 1'b0;
    l1_addr = '0; l1_wdata = '0; l1_we = 1'b0; l1_re = 1'b0;
    ref_rd = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_rdata", DM_readData, 64'd0);
    check("reset_ready", 64'(DM_ready), 64'd0);
    check("reset_busy", 64'(DM_busy), 64'd0);

    // Fill every word so the model knows all contents.
    for (int i = 0; i < DEPTH; i++)
      access(1'b1, 1'b0, 64'(i * 8), {$urandom(), $urandom()}, 1'b0, dummy);

    // Directed: write/read, both-enables write, address wrap.
    access(1'b1, 1'b0, 64'h18, 64'hDEADBEEF_CAFEF00D, 1'b0, dummy);
    access(1'b0, 1'b1, 64'h18, 64'h0, 1'b0, dummy);
    access(1'b1, 1'b1, 64'h08, 64'h5, 1'b0, dummy);
    access(1'b0, 1'b1, 64'h08, 64'h0, 1'b0, dummy);
    access(1'b1, 1'b0, 64'h200, 64'h77, 1'b0, dummy);
    access(1'b0, 1'b1, 64'h000, 64'h0, 1'b0, dummy);
    access(1'b0, 1'b1, 64'h007, 64'h0, 1'b0, dummy);
    check("wrap_model_word0", ref_rd, 64'h77);

    // Back-to-back reads with enables held through RESP.
    access(1'b0, 1'b1, 64'h00, 64'h0, 1'b1, r1);
    access(1'b0, 1'b1, 64'h08, 64'h0, 1'b0, r2);
    check("b2b_ready_spacing", 64'(r2 - r1), 64'(LAT + 2));

    // Reset in the first WAIT cycle aborts a write to 0x10.
    @(negedge clk);
    DM_addr = 64'h10; DM_writeData = 64'h1111_2222_3333_4444; DM_writeEnable = 1'b1;
    @(negedge clk);
    reset = 1'b1; DM_writeEnable = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    ref_rd = '0;
    r1 = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (DM_ready) r1++;
    end
    check("abort_no_ready", 64'(r1), 64'd0);
    check("abort_busy_idle", 64'(DM_busy), 64'd0);
    check("abort_rdata", DM_readData, 64'd0);
    access(1'b0, 1'b1, 64'h10, 64'h0, 1'b0, dummy);

    // Randomized traffic, including held enables and idle gaps.
    for (int i = 0; i < 150; i++) begin
      op   = int'($urandom_range(0, 2));
      hold = (i != 149) && ($urandom_range(0, 2) == 0);
      access(op != 1, op != 0, {$urandom(), $urandom()}, {$urandom(), $urandom()}, hold, dummy);
      if (!hold) begin
        gap = int'($urandom_range(0, 2));
        repeat (gap) @(negedge clk);
      end
    end

    // LATENCY=1 instance.
    access_l1(1'b1, 64'h28, 64'h1234, 64'h0);
    access_l1(1'b0, 64'h28, 64'h0, 64'h1234);
    access_l1(1'b1, 64'h30, 64'h99, 64'h1234);

    repeat (4) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter N, default 64, data and address width in bits.
REQ-002 Parameter DEPTH, default 64, number of N-bit words in the storage array (power of two).
REQ-003 Parameter LATENCY, default 2, number of WAIT cycles per access (legal range 1..15).
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 DM_addr  input  N  byte address from the pipeline memory stage.
REQ-007 DM_writeData  input  N  store data.
REQ-008 DM_writeEnable  input  1  store request, held until DM_ready.
REQ-009 DM_readEnable  input  1  load request, held until DM_ready.
REQ-010 DM_readData  output  N  registered load data; valid while DM_ready=1.
REQ-011 DM_ready  output  1  one-cycle completion pulse for the accepted access.
REQ-012 DM_busy  output  1  stall request to the pipeline.

Function
REQ-013 The block SHALL implement the FSM states IDLE, WAIT and RESP.
REQ-014 Word index SHALL be DM_addr[$clog2(DEPTH)+2:3]; DM_addr[2:0] and the upper bits SHALL be ignored, so out-of-range addresses wrap modulo DEPTH.
REQ-015 In IDLE, with DM_writeEnable or DM_readEnable high at a rising edge, the block SHALL latch the address, the data and the operation, load cnt with LATENCY-1, and enter WAIT.
REQ-016 When both enables are high, the access SHALL be a write; no read is performed and DM_readData holds its value.
REQ-017 In WAIT, cnt SHALL decrement each edge; when cnt==0, at that edge the block SHALL commit the access and enter RESP.
REQ-018 A committed write SHALL update the addressed word; a committed read SHALL load DM_readData from the addressed word.
REQ-019 Commit SHALL occur exactly LATENCY edges after the accept edge.
REQ-020 In RESP, DM_ready SHALL be 1 for exactly one cycle, and the FSM SHALL return to IDLE unconditionally; enables seen in RESP SHALL NOT start a new access.
REQ-021 DM_busy SHALL be 1 in WAIT, SHALL be (DM_readEnable|DM_writeEnable) combinationally in IDLE, and SHALL be 0 in RESP.
REQ-022 DM_readData SHALL hold its last committed read value and change only on a read commit or reset.
REQ-023 Back-to-back accesses SHALL each take LATENCY+2 cycles from request presentation to the next acceptance opportunity (IDLE, WAIT×LATENCY, RESP).
REQ-024 Input changes during WAIT SHALL NOT affect the latched access.

Reset
REQ-025 Reset SHALL force state=IDLE, cnt=0, DM_readData=0 and DM_ready=0; DM_busy then follows REQ-021.
REQ-026 Reset asserted in WAIT SHALL abort the access: no write is committed and no DM_ready pulse is produced.
REQ-027 The storage array SHALL NOT be cleared by reset; its contents SHALL persist across reset.

Structure
REQ-028 A shared package SHALL hold the dmem_state_t enum (IDLE, WAIT, RESP) and the default DEPTH/LATENCY constants.
REQ-029 Storage SHALL be a separate sub-module, dmem_array, with a synchronous write port and a registered read port; the FSM, the counter and the latches SHALL reside in dmem_responder.

Verification
REQ-030 Write 0xDEADBEEF_CAFEF00D to addr 0x18, LATENCY=2 -> DM_busy=1 for 3 cycles, DM_ready pulses 3 cycles after request; then read 0x18 -> DM_readData=0xDEADBEEF_CAFEF00D during DM_ready.
REQ-031 Both enables high, addr 0x08, data 0x5 -> word 1=0x5 after the commit; DM_readData unchanged from its prior value.
REQ-032 Write 0x77 to addr 0x200 with DEPTH=64 -> read of addr 0x000 returns 0x77 (wrap); read of addr 0x007 also returns 0x77.
REQ-033 Write to 0x10 with reset pulsed in the first WAIT cycle -> no DM_ready, state IDLE, DM_readData=0; a later read of 0x10 returns the old contents.
REQ-034 Two consecutive reads of 0x00 and 0x08 with enables held across RESP -> exactly two DM_ready pulses, 4 cycles apart with LATENCY=2.
REQ-035 LATENCY=1 -> DM_ready is asserted 2 cycles after request presentation; DM_busy is high for exactly 2 cycles.
